// File: rtl/timer_pkg.sv
// Shared encodings for the stopwatch/countdown timer: FSM states, ctrl bit
// positions and count-direction constants.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_STOP  = 1;
  localparam int unsigned CTRL_PAUSE = 2;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by CLK_DIV while enabled; wrap_now flags the last cycle of each
// period so the owner can update its seconds count on that edge.
module tick_prescaler #(
  parameter int unsigned CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic wrap_now
);

  localparam int unsigned    CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign wrap_now = en && (count == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (wrap_now) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_timer.sv
// Seconds stopwatch / countdown timer with preset load and status pulses.
// Optional lap capture (lap, lap_sec, lap_valid) is built when LAP_CAPTURE_EN is defined.
module stopwatch_timer
  import timer_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50_000_000,
  parameter int unsigned SEC_W   = 16,
  parameter int unsigned SEC_MAX = 2**SEC_W - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       ctrl,
  input  logic             mode,
  input  logic             load,
  input  logic [SEC_W-1:0] load_val,
  output logic [SEC_W-1:0] sec,
  output logic             tick,
  output logic             running,
  output logic             done,
  output logic             wrap
`ifdef LAP_CAPTURE_EN
  ,
  input  logic             lap,
  output logic [SEC_W-1:0] lap_sec,
  output logic             lap_valid
`endif
);

  localparam logic [SEC_W-1:0] SEC_MAX_V = SEC_W'(SEC_MAX);
  localparam logic [SEC_W-1:0] SEC_ONE   = SEC_W'(1);

  state_t           state, state_next;
  logic [SEC_W-1:0] sec_next;
  logic             mode_q, mode_next, mode_eff;
  logic             tick_next, done_next, wrap_next;
  logic             start, stop, pause, stop_take;
  logic             pre_en, pre_clr, pre_wrap;

  assign start     = ctrl[CTRL_START];
  assign stop      = ctrl[CTRL_STOP];
  assign pause     = ctrl[CTRL_PAUSE];
  assign stop_take = stop && !start;

  // Start has priority, so a start seen in RUN keeps the prescaler advancing
  // even when stop/pause are raised alongside it.
  assign pre_en = (state == ST_RUN) && (start || !(stop || pause));

  tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clr      (pre_clr),
    .en       (pre_en),
    .wrap_now (pre_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    sec_next   = sec;
    mode_next  = mode_q;
    tick_next  = 1'b0;
    done_next  = 1'b0;
    wrap_next  = 1'b0;
    pre_clr    = 1'b0;
    mode_eff   = (state == ST_PAUSE) ? mode_q : mode;

    if (start) begin
      if (state != ST_RUN && !(mode_eff == MODE_DOWN && sec == '0)) begin
        state_next = ST_RUN;
        mode_next  = mode_eff;
        pre_clr    = (state != ST_PAUSE);
      end
    end else if (stop) begin
      state_next = ST_IDLE;
      sec_next   = '0;
      pre_clr    = 1'b1;
    end else if (pause) begin
      if (state == ST_RUN) begin
        state_next = ST_PAUSE;
      end
    end else if (load && state != ST_RUN) begin
      sec_next = load_val;
      pre_clr  = 1'b1;
      if (state == ST_DONE) begin
        state_next = ST_IDLE;
      end
    end

    // pre_wrap implies RUN with the prescaler enabled, so no branch above
    // has touched sec_next in that case.
    if (pre_wrap) begin
      tick_next = 1'b1;
      if (mode_q == MODE_UP) begin
        if (sec == SEC_MAX_V) begin
          sec_next  = '0;
          wrap_next = 1'b1;
        end else begin
          sec_next = sec + SEC_ONE;
        end
      end else if (sec != '0) begin
        sec_next = sec - SEC_ONE;
        if (sec == SEC_ONE) begin
          done_next  = 1'b1;
          state_next = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec     <= '0;
      mode_q  <= MODE_UP;
      tick    <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
      running <= 1'b0;
    end else begin
      sec     <= sec_next;
      mode_q  <= mode_next;
      tick    <= tick_next;
      done    <= done_next;
      wrap    <= wrap_next;
      running <= (state_next == ST_RUN);
    end
  end

`ifdef LAP_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (rst || stop_take) begin
      lap_sec   <= '0;
      lap_valid <= 1'b0;
    end else if (lap && state == ST_RUN) begin
      lap_sec   <= sec;
      lap_valid <= 1'b1;
    end
  end
`endif

endmodule
